// File: rtl/my_memory_mmio.sv
// my_memory_mmio: Hack-style memory map with RAM, screen buffer, a queued keyboard port and
// an optional keyboard status word, all behind one data bus.
//
// Address map (R = 2**RAM_AW, S = 2**SCREEN_AW):
//   [0, R)      main RAM
//   [R, R+S)    screen buffer
//   R+S         KBD: FIFO head on read (0 when empty); write pops the head
//   R+S+1       STATUS: {overflow, 0.., kbd_count} when enabled; write clears overflow
//   others      read 0, writes ignored
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      synchronous active-high reset (FIFO state only; RAM/screen keep contents)
//   in         write data
//   addr       word address (RAM_AW+1 bits)
//   load       write enable for addr
//   out        combinational read data
//   kbd_data   scancode from host
//   kbd_valid  host offers a scancode
//   kbd_ready  FIFO accepts a push this cycle
//   kbd_count  FIFO occupancy
//
// Optional feature macro: MY_MEMORY_MMIO_KBD_STATUS_EN enables the STATUS word and the sticky
// overflow flag. Without it STATUS reads 0 and refused pushes are dropped silently.
module my_memory_mmio #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_AW    = 14,
  parameter int unsigned SCREEN_AW = 13,
  parameter int unsigned KBD_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            in,
  input  logic [RAM_AW:0]              addr,
  input  logic                         load,
  output logic [DATA_W-1:0]            out,
  input  logic [DATA_W-1:0]            kbd_data,
  input  logic                         kbd_valid,
  output logic                         kbd_ready,
  output logic [$clog2(KBD_DEPTH):0]   kbd_count
);

  localparam int unsigned PtrW  = $clog2(KBD_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned AddrW = RAM_AW + 1;
  localparam logic [AddrW-1:0] KbdAddr = AddrW'((2 ** RAM_AW) + (2 ** SCREEN_AW));

  // Address decode
  logic sel_ram, sel_screen, sel_kbd;

  assign sel_ram    = !addr[RAM_AW];
  assign sel_screen = addr[RAM_AW] && (addr[RAM_AW-1:SCREEN_AW] == '0);
  assign sel_kbd    = (addr == KbdAddr);

  // RAM and screen: async read, sync write, never cleared (writes proceed during reset)
  logic [DATA_W-1:0] ram_q    [2 ** RAM_AW];
  logic [DATA_W-1:0] screen_q [2 ** SCREEN_AW];

  always_ff @(posedge clk) begin
    if (load && sel_ram)    ram_q[addr[RAM_AW-1:0]]       <= in;
    if (load && sel_screen) screen_q[addr[SCREEN_AW-1:0]] <= in;
  end

  // Keyboard FIFO
  logic [DATA_W-1:0] fifo_q [KBD_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, push_wr, pop;

  assign full      = (count_q == CntW'(KBD_DEPTH));
  // Depends only on registered state and reset, never on the CPU side of the bus.
  assign kbd_ready = !full && !reset;
  assign kbd_count = count_q;

  // A zero scancode completes the handshake but is never stored, so KBD==0 means empty.
  assign push_wr = kbd_valid && kbd_ready && (kbd_data != '0);
  // Popping an empty FIFO is a no-op, which also covers push+pop while empty.
  assign pop     = load && sel_kbd && (count_q != '0) && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_wr && !pop)      count_d = count_q + CntW'(1);
    else if (!push_wr && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_wr) fifo_q[wr_ptr_q] <= kbd_data;
  end

`ifdef MY_MEMORY_MMIO_KBD_STATUS_EN
  localparam logic [AddrW-1:0] StatusAddr = AddrW'((2 ** RAM_AW) + (2 ** SCREEN_AW) + 1);

  logic              sel_status;
  logic              overflow_q;
  logic [DATA_W-1:0] status_word;

  assign sel_status = (addr == StatusAddr);

  // Sticky; a refused nonzero push in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)                                      overflow_q <= 1'b0;
    else if (kbd_valid && full && kbd_data != '0)   overflow_q <= 1'b1;
    else if (load && sel_status)                    overflow_q <= 1'b0;
  end

  always_comb begin
    status_word               = '0;
    status_word[CntW-1:0]     = count_q;
    status_word[DATA_W-1]     = overflow_q;
  end
`endif

  // Read mux
  always_comb begin
    out = '0;
    if (sel_ram)         out = ram_q[addr[RAM_AW-1:0]];
    else if (sel_screen) out = screen_q[addr[SCREEN_AW-1:0]];
    else if (sel_kbd)    out = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
`ifdef MY_MEMORY_MMIO_KBD_STATUS_EN
    else if (sel_status) out = status_word;
`endif
  end

endmodule

// File: tb/tb_my_memory_mmio.sv
// Testbench for my_memory_mmio: directed vector table, hand-written FIFO/reset/status
// sequences, then randomized traffic against a queue-based reference model.
module tb_my_memory_mmio;

  localparam int DW    = 16;
  localparam int RAW   = 14;
  localparam int SAW   = 13;
  localparam int DEPTH = 8;
  localparam int R     = 1 << RAW;
  localparam int S     = 1 << SAW;
  localparam int KBD   = R + S;
  localparam int STAT  = R + S + 1;

  logic          clk = 1'b0;
  logic          reset, load, kbd_valid, kbd_ready;
  logic [DW-1:0] din, dout, kbd_data;
  logic [RAW:0]  addr;
  logic [3:0]    kbd_count;

  int nvec = 0;
  int nmis = 0;

  my_memory_mmio #(
    .DATA_W   (DW),
    .RAM_AW   (RAW),
    .SCREEN_AW(SAW),
    .KBD_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .addr     (addr),
    .load     (load),
    .out      (dout),
    .kbd_data (kbd_data),
    .kbd_valid(kbd_valid),
    .kbd_ready(kbd_ready),
    .kbd_count(kbd_count)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a sparse map, keyboard as a queue.
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_q [$];
  bit            m_ovf;

  function automatic bit m_known(int a);
    return (a >= R + S) || m_mem.exists(a);
  endfunction

  function automatic logic [DW-1:0] m_out(int a);
    logic [DW-1:0] s;
    s = '0;
    if (a < R + S) return m_mem.exists(a) ? m_mem[a] : '0;
    if (a == KBD) return (m_q.size() > 0) ? m_q[0] : '0;
`ifdef MY_MEMORY_MMIO_KBD_STATUS_EN
    if (a == STAT) begin
      s[DW-1] = m_ovf;
      s[3:0]  = 4'(m_q.size());
      return s;
    end
`endif
    return s;
  endfunction

  task automatic model_edge();
    int a;
    bit full, do_push, do_pop;
    a    = int'(addr);
    full = (m_q.size() >= DEPTH);
    if (load && a < R + S) m_mem[a] = din;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      do_push = kbd_valid && !full && (kbd_data != '0);
      do_pop  = load && (a == KBD) && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(kbd_data);
      if (kbd_valid && full && kbd_data != '0) m_ovf = 1'b1;
      else if (load && a == STAT)             m_ovf = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit ld, input int a, input logic [DW-1:0] d,
                       input bit kv, input logic [DW-1:0] kd);
    reset     = r;
    load      = ld;
    addr      = (RAW + 1)'(a);
    din       = d;
    kbd_valid = kv;
    kbd_data  = kd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit            rst;
    bit            ld;
    int            a;
    logic [DW-1:0] din;
    bit            kv;
    logic [DW-1:0] kd;
    bit            chk_out;
    logic [DW-1:0] eo;
    int            ec;
    bit            er;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(bit ld, int a, logic [DW-1:0] d, bit kv, logic [DW-1:0] kd,
                             bit co, logic [DW-1:0] eo, int ec, bit er);
    vec_t t;
    t.rst = 1'b0; t.ld = ld; t.a = a; t.din = d; t.kv = kv; t.kd = kd;
    t.chk_out = co; t.eo = eo; t.ec = ec; t.er = er;
    return t;
  endfunction

  initial begin
    // Directed table; expectations are outputs seen before the clock edge of each row.
    tbl.push_back(v(1, 0,       16'h1234, 0, 0,       0, 0,        0, 1));
    tbl.push_back(v(1, R+S-1,   16'hBEEF, 0, 0,       0, 0,        0, 1));
    tbl.push_back(v(0, 0,       0,        0, 0,       1, 16'h1234, 0, 1));
    tbl.push_back(v(0, R+S-1,   0,        0, 0,       1, 16'hBEEF, 0, 1));
    tbl.push_back(v(1, R+S+2,   16'h5555, 0, 0,       1, 0,        0, 1));
    tbl.push_back(v(0, R+S+2,   0,        0, 0,       1, 0,        0, 1));
    tbl.push_back(v(0, KBD,     0,        1, 16'h0041, 1, 0,       0, 1));
    tbl.push_back(v(0, KBD,     0,        1, 16'h0042, 1, 16'h0041, 1, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 16'h0041, 2, 1));
    tbl.push_back(v(1, KBD,     16'hFFFF, 0, 0,       1, 16'h0041, 2, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 16'h0042, 1, 1));
    tbl.push_back(v(1, KBD,     0,        0, 0,       1, 16'h0042, 1, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 0,        0, 1));
    tbl.push_back(v(1, KBD,     0,        0, 0,       1, 0,        0, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 0,        0, 1));
    tbl.push_back(v(0, KBD,     0,        1, 16'h0000, 1, 0,       0, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 0,        0, 1));
    tbl.push_back(v(1, KBD,     0,        1, 16'h0077, 1, 0,       0, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 16'h0077, 1, 1));
    tbl.push_back(v(1, KBD,     0,        0, 0,       1, 16'h0077, 1, 1));
    tbl.push_back(v(0, KBD,     0,        0, 0,       1, 0,        0, 1));

    // Initial reset
    drive(1, 0, KBD, 0, 0, 0);
    chk("ready_in_reset", kbd_ready, 0);
    tick();
    drive(0, 0, KBD, 0, 0, 0);
    chk("reset_count", kbd_count, 0);
    chk("reset_kbd", dout, 0);
    chk("reset_ready", kbd_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].a, tbl[i].din, tbl[i].kv, tbl[i].kd);
      if (tbl[i].chk_out) chk($sformatf("tbl[%0d] out", i), dout, tbl[i].eo);
      chk($sformatf("tbl[%0d] count", i), kbd_count, tbl[i].ec);
      chk($sformatf("tbl[%0d] ready", i), kbd_ready, tbl[i].er);
      tick();
    end

    // Fill to full, refused push, status, pop under full, push+pop, drain order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, KBD, 0, 1, 16'h0101 + 16'(i));
      chk($sformatf("fill[%0d] count", i), kbd_count, i);
      tick();
    end
    drive(0, 0, KBD, 0, 1, 16'h0099);
    chk("full_ready", kbd_ready, 0);
    chk("full_count", kbd_count, DEPTH);
    chk("full_head", dout, 16'h0101);
    tick();
    drive(0, 0, STAT, 0, 0, 0);
`ifdef MY_MEMORY_MMIO_KBD_STATUS_EN
    chk("status_ovf", dout, 16'h8000 | DEPTH);
`else
    chk("status_off", dout, 0);
`endif
    drive(0, 1, STAT, 16'hFFFF, 0, 0);
    tick();
    drive(0, 0, STAT, 0, 0, 0);
`ifdef MY_MEMORY_MMIO_KBD_STATUS_EN
    chk("status_clr", dout, DEPTH);
`else
    chk("status_off_wr", dout, 0);
`endif
    drive(0, 1, KBD, 0, 1, 16'h0099);   // full: only the pop happens
    chk("popfull_ready", kbd_ready, 0);
    tick();
    drive(0, 1, KBD, 0, 1, 16'h0099);   // not full: push and pop together
    chk("pushpop_count_before", kbd_count, DEPTH - 1);
    chk("pushpop_ready", kbd_ready, 1);
    tick();
    drive(0, 0, KBD, 0, 0, 0);
    chk("pushpop_count_after", kbd_count, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(0, 1, KBD, 0, 0, 0);
      chk($sformatf("drain[%0d]", i), dout, (i < DEPTH - 2) ? 16'h0103 + 16'(i) : 16'h0099);
      tick();
    end
    drive(0, 0, KBD, 0, 0, 0);
    chk("drain_empty", dout, 0);
    chk("drain_count", kbd_count, 0);

    // Mid-operation reset: FIFO cleared, RAM kept, RAM write in reset cycle lands.
    drive(0, 1, 5, 16'hABCD, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, KBD, 0, 1, 16'h0061 + 16'(i));
      tick();
    end
    drive(1, 1, 6, 16'h6666, 1, 16'h0055);
    chk("rst3_count_before", kbd_count, 3);
    chk("rst3_ready_in_reset", kbd_ready, 0);
    tick();
    drive(0, 0, KBD, 0, 0, 0);
    chk("rst3_count", kbd_count, 0);
    chk("rst3_kbd", dout, 0);
    chk("rst3_ready", kbd_ready, 1);
    drive(0, 0, 5, 0, 0, 0);
    chk("rst3_ram_kept", dout, 16'hABCD);
    drive(0, 0, 6, 0, 0, 0);
    chk("rst3_ram_wr", dout, 16'h6666);

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, i, 16'($urandom), 0, 0);
      tick();
      drive(0, 1, R + i, 16'($urandom), 0, 0);
      tick();
    end
    for (int n = 0; n < 3000; n++) begin
      int sel, a;
      bit ld, kv, rst;
      logic [DW-1:0] kd;
      sel = $urandom_range(0, 9);
      if (sel <= 2)      a = $urandom_range(0, 15);
      else if (sel <= 4) a = R + $urandom_range(0, 15);
      else if (sel <= 7) a = KBD;
      else if (sel == 8) a = STAT;
      else               a = STAT + 1 + $urandom_range(0, 100);
      ld  = ($urandom_range(0, 2) == 0);
      kv  = $urandom_range(0, 1) == 1;
      kd  = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom_range(1, 16'hFFFF));
      rst = ($urandom_range(0, 99) == 0);
      drive(rst, ld, a, 16'($urandom), kv, kd);
      if (m_known(a)) chk($sformatf("rnd[%0d] out a=%0h", n, a), dout, m_out(a));
      chk($sformatf("rnd[%0d] count", n), kbd_count, m_q.size());
      chk($sformatf("rnd[%0d] ready", n), kbd_ready, !rst && (m_q.size() < DEPTH));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
